// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_arbiter
// Description : Round-robin arbiter that shares one block-wide memory port
//               between NUM_REQ cache requesters. Each grant becomes a single
//               memory command. Read data is routed back to the granted
//               requester, and a watchdog aborts transactions whose memory
//               ready never arrives.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_arbiter #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 16,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_REQ-1:0]                     req_read,
  input  logic [NUM_REQ-1:0]                     req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]          req_addr,
  input  logic [NUM_REQ*BLOCK_SIZE*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                     req_ack,
  output logic [NUM_REQ-1:0]                     req_err,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]       rsp_rdata,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]       mem_wdata,
  output logic                                   mem_read,
  output logic                                   mem_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]       mem_rdata,
  input  logic                                   mem_ready,
  output logic                                   busy
);

  localparam int BLK_W = BLOCK_SIZE * DATA_WIDTH;
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);

  // Clears the word-within-block bits so every command is block aligned.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(BLOCK_SIZE - 1));
  // Last WAIT cycle allowed before the transaction is aborted.
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               state;
  state_t               next_state;

  // Transaction context held from grant until the response cycle.
  logic [IDX_W-1:0]     rr_ptr;
  logic [IDX_W-1:0]     grant;
  logic                 op_write;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BLK_W-1:0]     wdata_q;
  logic [BLK_W-1:0]     rdata_q;
  logic [CNT_W-1:0]     cnt;
  logic                 timed_out;

  // Arbitration results.
  logic [NUM_REQ-1:0]   req_any;
  logic                 arb_found;
  logic [IDX_W-1:0]     arb_idx;
  int                   scan;

  // Request fields of the arbitration winner.
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [BLK_W-1:0]     sel_wdata;
  logic                 sel_write;

  // Response strobes decoded from the FSM.
  logic                 resp_ok;
  logic                 resp_err;
  logic                 wait_expired;

  // A requester holding both strobes is served as a write.
  assign req_any      = req_read | req_write;
  assign wait_expired = (cnt == CNT_LAST);

  // Round-robin search starting at rr_ptr, wrapping at NUM_REQ; first pending wins.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    scan      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = int'(rr_ptr) + i;
      if (scan >= NUM_REQ) begin
        scan = scan - NUM_REQ;
      end
      if (!arb_found && req_any[scan[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = scan[IDX_W-1:0];
      end
    end
  end

  // Multiplex the winner's address, write block and operation.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*BLK_W +: BLK_W];
        sel_write = req_write[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and per-state memory strobes / response strobes.
  always_comb begin
    next_state = state;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    resp_ok    = 1'b0;
    resp_err   = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (arb_found) begin
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mem_read   = !op_write;
        mem_write  = op_write;
        next_state = S_WAIT;
      end
      S_WAIT: begin
        // Ready on the final allowed cycle still counts as success.
        if (mem_ready || wait_expired) begin
          next_state = S_RESP;
        end
      end
      S_RESP: begin
        resp_ok    = !timed_out;
        resp_err   = timed_out;
        next_state = S_IDLE;
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  // Latch the winning request's context when a grant is made.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (state == S_IDLE && arb_found) begin
      grant    <= arb_idx;
      op_write <= sel_write;
      addr_q   <= sel_addr & ALIGN_MASK;
      wdata_q  <= sel_wdata;
    end
  end

  // Watchdog: cleared on issue, counts WAIT cycles without ready, flags expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      timed_out <= 1'b0;
    end else if (state == S_ISSUE) begin
      cnt       <= '0;
      timed_out <= 1'b0;
    end else if (state == S_WAIT && !mem_ready) begin
      if (wait_expired) begin
        timed_out <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Capture the read block on ready; writes leave the previous block in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (state == S_WAIT && mem_ready && !op_write) begin
      rdata_q <= mem_rdata;
    end
  end

  // Advance the round-robin pointer past the requester just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (state == S_RESP) begin
      rr_ptr <= (grant == IDX_LAST) ? '0 : grant + 1'b1;
    end
  end

  // One-hot completion and timeout pulses steered to the granted requester.
  generate
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_resp
      assign req_ack[g] = resp_ok  && (grant == IDX_W'(g));
      assign req_err[g] = resp_err && (grant == IDX_W'(g));
    end
  endgenerate

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rsp_rdata = rdata_q;

endmodule
`default_nettype wire
